// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// uart_tx_ctrl : UART transmit frame sequencer (start, data LSB first,
//                optional parity, stop). One CLK cycle is one bit time.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module uart_tx_ctrl #(
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Data_Valid,
    input  logic                     PAR_EN,
    output logic                     ser_en,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic [1:0]               mux_sel,
    output logic                     Busy,
    output logic                     frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_IDLE   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            stop_cnt, stop_cnt_d;
    logic            par_en_q, par_en_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            bit_cnt_q <= '0;
            stop_cnt  <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt_q <= bit_cnt_d;
            stop_cnt  <= stop_cnt_d;
            par_en_q  <= par_en_d;
        end
    end

    // Outputs depend only on registered state and counters.
    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt;
        par_en_d   = par_en_q;
        Busy       = 1'b1;
        mux_sel    = SEL_IDLE;
        ser_en     = 1'b0;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                Busy       = 1'b0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                if (Data_Valid) begin
                    state_d  = START;
                    par_en_d = PAR_EN;
                end
            end
            START: begin
                mux_sel   = SEL_START;
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                mux_sel = SEL_DATA;
                ser_en  = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = par_en_q ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            PARITY: begin
                mux_sel    = SEL_PARITY;
                stop_cnt_d = 1'b0;
                state_d    = STOP;
            end
            STOP: begin
                if (stop_cnt == LAST_STOP) begin
                    frame_done = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    stop_cnt_d = stop_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bit_cnt = bit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// tb_uart_tx_ctrl : checks two sequencer instances (1 and 2 stop bits)
//                   cycle by cycle against a frame-position reference model.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;

    logic       ser_en_a, busy_a, done_a;
    logic [2:0] bit_cnt_a;
    logic [1:0] mux_sel_a;
    logic       ser_en_b, busy_b, done_b;
    logic [2:0] bit_cnt_b;
    logic [1:0] mux_sel_b;

    int tests = 0;
    int fails = 0;

    int pos [2];
    bit pel [2];
    int sb  [2];
    int run [2];
    int last_run [2];

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.WIDTH(W), .STOP_BITS(1)) dut_a (
        .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
        .ser_en(ser_en_a), .bit_cnt(bit_cnt_a), .mux_sel(mux_sel_a),
        .Busy(busy_a), .frame_done(done_a)
    );

    uart_tx_ctrl #(.WIDTH(W), .STOP_BITS(2)) dut_b (
        .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .PAR_EN(PAR_EN),
        .ser_en(ser_en_b), .bit_cnt(bit_cnt_b), .mux_sel(mux_sel_b),
        .Busy(busy_b), .frame_done(done_b)
    );

    // Expected {Busy, mux_sel, ser_en, bit_cnt, frame_done} at frame position p
    // (p < 0 means idle): start, W data bits, optional parity, sb stop bits.
    function automatic logic [7:0] expv(int p, bit pe, int nstop);
        logic [7:0] v;
        int s;
        v = {1'b0, 2'b01, 1'b0, 3'd0, 1'b0};
        if (p == 0)
            v = {1'b1, 2'b00, 1'b0, 3'd0, 1'b0};
        else if (p >= 1 && p <= W)
            v = {1'b1, 2'b10, 1'b1, 3'(p - 1), 1'b0};
        else if (p == W + 1 && pe)
            v = {1'b1, 2'b11, 1'b0, 3'd0, 1'b0};
        else if (p > 0) begin
            s = p - 1 - W - int'(pe);
            v = {1'b1, 2'b01, 1'b0, 3'd0, (s == nstop - 1)};
        end
        return v;
    endfunction

    task automatic check_all(input string tag);
        logic [7:0] obs [2];
        logic [7:0] exp_v;
        logic       bsy;
        obs[0] = {busy_a, mux_sel_a, ser_en_a, bit_cnt_a, done_a};
        obs[1] = {busy_b, mux_sel_b, ser_en_b, bit_cnt_b, done_b};
        for (int i = 0; i < 2; i++) begin
            exp_v = expv(pos[i], pel[i], sb[i]);
            tests++;
            assert (obs[i] === exp_v) else begin
                fails++;
                $error("FAIL %s dut%0d t=%0t observed=%b expected=%b (busy,mux,ser,bit,done)",
                       tag, i, $time, obs[i], exp_v);
            end
            bsy = obs[i][7];
            if (bsy === 1'b1) run[i]++;
            else if (run[i] != 0) begin
                last_run[i] = run[i];
                run[i] = 0;
            end
        end
    endtask

    task automatic check_run(input string tag, input int i, input int want);
        tests++;
        assert (last_run[i] === want) else begin
            fails++;
            $error("FAIL %s dut%0d busy_cycles observed=%0d expected=%0d", tag, i, last_run[i], want);
        end
    endtask

    task automatic step(input bit dv, input bit pe, input string tag);
        @(negedge CLK);
        Data_Valid = dv;
        PAR_EN     = pe;
        for (int i = 0; i < 2; i++) begin
            if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] == 1 + W + int'(pel[i]) + sb[i]) pos[i] = -1;
            end else if (dv) begin
                pos[i] = 0;
                pel[i] = pe;
            end
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, "idle");
    endtask

    // Asynchronous reset asserted between edges; outputs must go idle at once.
    task automatic reset_pulse(input string tag);
        #1;
        RST        = 1'b0;
        Data_Valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            pos[i] = -1;
            run[i] = 0;
        end
        check_all(tag);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        bit reached;
        sb[0] = 1;
        sb[1] = 2;
        for (int i = 0; i < 2; i++) begin
            pos[i] = -1; pel[i] = 1'b0; run[i] = 0; last_run[i] = 0;
        end
        RST = 1'b0;
        Data_Valid = 1'b0;
        PAR_EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        @(negedge CLK);
        RST = 1'b1;
        idle_steps(2);

        // 1: single pulse, parity on
        step(1'b1, 1'b1, "t1_accept");
        for (int k = 0; k < 14; k++) step(1'b0, 1'b1, "t1_frame");
        check_run("t1_busy", 0, 11);
        check_run("t1_busy", 1, 12);

        // 2: parity off
        step(1'b1, 1'b0, "t2_accept");
        for (int k = 0; k < 14; k++) step(1'b0, 1'b0, "t2_frame");
        check_run("t2_busy", 0, 10);
        check_run("t2_busy", 1, 11);

        // 3: Data_Valid pulse while bit_cnt=3 is ignored
        step(1'b1, 1'b1, "t3_accept");
        repeat (4) step(1'b0, 1'b1, "t3_frame");
        step(1'b1, 1'b1, "t3_dv_in_data");
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, "t3_tail");
        check_run("t3_busy", 0, 11);

        // 4: Data_Valid held high for 30 cycles
        for (int k = 0; k < 30; k++) step(1'b1, 1'b1, "t4_held");
        idle_steps(15);
        check_run("t4_busy", 0, 11);

        // 5: PAR_EN drops mid-frame, parity still sent
        step(1'b1, 1'b1, "t5_accept");
        repeat (3) step(1'b0, 1'b1, "t5_frame");
        for (int k = 0; k < 14; k++) step(1'b0, 1'b0, "t5_par_dropped");
        check_run("t5_busy", 0, 11);
        check_run("t5_busy", 1, 12);

        // 6: reset while bit_cnt=5
        step(1'b1, 1'b1, "t6_accept");
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            step(1'b0, 1'b1, "t6_frame");
            if (pos[0] == 6) reached = 1'b1;
        end
        tests++;
        assert (reached) else begin
            fails++;
            $error("FAIL t6_reach observed=%0d expected=%0d", pos[0], 6);
        end
        reset_pulse("t6_reset");
        idle_steps(12);
        step(1'b1, 1'b0, "t6_restart");
        idle_steps(14);

        // randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 59) == 0) reset_pulse("rand_reset");
        end
        idle_steps(15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
